tio_wb_arbiter: RTL

Two-master round-robin WISHBONE classic arbiter that shares the TURFIO housekeeping register space (ID/control, clock monitors and downstream targets) between the debug board-manager master (m0) and the housekeeping-bus master (m1). It grants one master at a time and holds the grant for the whole `cyc` period, so multi-access cycles are never interleaved. An optional watchdog aborts target accesses that never respond, such as accesses into a stopped clock domain, so that neither master deadlocks.

---
 rtl/tio_wb_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/tio_wb_arbiter.sv
// Two-master round-robin WISHBONE classic arbiter; grant is held for the whole cyc period.
// Optional watchdog abort of unresponsive target accesses is enabled by WB_ARB_TIMEOUT_EN.
module tio_wb_arbiter #(
  parameter int unsigned ADR_WIDTH = 12,
  parameter int unsigned DAT_WIDTH = 32,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   m0_cyc_i,
  input  logic                   m0_stb_i,
  input  logic                   m0_we_i,
  input  logic [ADR_WIDTH-1:0]   m0_adr_i,
  input  logic [DAT_WIDTH-1:0]   m0_dat_i,
  input  logic [DAT_WIDTH/8-1:0] m0_sel_i,
  output logic                   m0_ack_o,
  output logic                   m0_err_o,
  output logic                   m0_rty_o,
  output logic [DAT_WIDTH-1:0]   m0_dat_o,
  input  logic                   m1_cyc_i,
  input  logic                   m1_stb_i,
  input  logic                   m1_we_i,
  input  logic [ADR_WIDTH-1:0]   m1_adr_i,
  input  logic [DAT_WIDTH-1:0]   m1_dat_i,
  input  logic [DAT_WIDTH/8-1:0] m1_sel_i,
  output logic                   m1_ack_o,
  output logic                   m1_err_o,
  output logic                   m1_rty_o,
  output logic [DAT_WIDTH-1:0]   m1_dat_o,
  output logic                   s_cyc_o,
  output logic                   s_stb_o,
  output logic                   s_we_o,
  output logic [ADR_WIDTH-1:0]   s_adr_o,
  output logic [DAT_WIDTH-1:0]   s_dat_o,
  output logic [DAT_WIDTH/8-1:0] s_sel_o,
  input  logic                   s_ack_i,
  input  logic                   s_err_i,
  input  logic                   s_rty_i,
  input  logic [DAT_WIDTH-1:0]   s_dat_i,
  output logic [1:0]             grant_o,
  output logic [7:0]             timeout_cnt_o
);

`ifdef WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1, StAbort} state_e;
`else
  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;
`endif

  state_e     state_q;
  logic       last_q;
  logic [1:0] grant_q;
  logic       own0, own1, own_cyc, resp, wdg_fire;

  always_comb begin
    own0    = (state_q == StOwn0);
    own1    = (state_q == StOwn1);
    // last_q always names the current owner while a grant is held (including abort)
    own_cyc = last_q ? m1_cyc_i : m0_cyc_i;
    resp    = s_ack_i | s_err_i | s_rty_i;

    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    if (own0) begin
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
      s_we_o  = m0_we_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
    end else if (own1) begin
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
      s_we_o  = m1_we_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [7:0] wdg_q;
  logic [7:0] tcnt_q;
  logic       stall;

  assign stall         = s_cyc_o & s_stb_o & ~resp;
  assign wdg_fire      = stall && (wdg_q == 8'(TIMEOUT));
  assign timeout_cnt_o = tcnt_q;
`else
  assign wdg_fire      = 1'b0;
  assign timeout_cnt_o = 8'd0;
`endif

  assign m0_ack_o = own0 & s_ack_i;
  assign m0_err_o = own0 & (s_err_i | wdg_fire);
  assign m0_rty_o = own0 & s_rty_i;
  assign m0_dat_o = own0 ? s_dat_i : '0;
  assign m1_ack_o = own1 & s_ack_i;
  assign m1_err_o = own1 & (s_err_i | wdg_fire);
  assign m1_rty_o = own1 & s_rty_i;
  assign m1_dat_o = own1 ? s_dat_i : '0;
  assign grant_o  = grant_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      grant_q <= 2'b00;
`ifdef WB_ARB_TIMEOUT_EN
      wdg_q   <= 8'd0;
      tcnt_q  <= 8'd0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          // Tie goes to the master that was not granted last
          if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
            state_q <= StOwn0;
            last_q  <= 1'b0;
            grant_q <= 2'b01;
          end else if (m1_cyc_i) begin
            state_q <= StOwn1;
            last_q  <= 1'b1;
            grant_q <= 2'b10;
          end
        end
        StOwn0, StOwn1: begin
          if (!own_cyc) begin
            state_q <= StIdle;
            grant_q <= 2'b00;
`ifdef WB_ARB_TIMEOUT_EN
            wdg_q   <= 8'd0;
          end else if (wdg_fire) begin
            state_q <= StAbort;
            wdg_q   <= 8'd0;
            if (tcnt_q != 8'hFF) tcnt_q <= tcnt_q + 8'd1;
          end else if (resp) begin
            wdg_q <= 8'd0;
          end else if (stall) begin
            wdg_q <= wdg_q + 8'd1;
`endif
          end
        end
`ifdef WB_ARB_TIMEOUT_EN
        StAbort: begin
          if (!own_cyc) begin
            state_q <= StIdle;
            grant_q <= 2'b00;
          end
        end
`endif
        default: begin
          state_q <= StIdle;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

endmodule
